if_prefetch_queue: RTL and testbench

- Instruction-fetch front end between the variable-latency instruction memory and the IF/ID pipeline register.
- Keeps a fetch PC and issues one instruction-memory request at a time.
- Buffers returned instructions together with their PC+4 in a small FIFO, and presents the head entry to the IF/ID register.
- On a branch/jump redirect it flushes all buffered and in-flight fetches and restarts fetching at the target address.

---
 rtl/if_prefetch_queue.sv | 179 +++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue.
// Issues one instruction-memory request at a time from a running fetch PC,
// buffers returned words with their PC+4 in a small FIFO, and presents the
// head entry to the IF/ID register. A redirect flushes the FIFO and any
// in-flight fetch, then restarts fetching at the (word-aligned) target.
//
// Memory handshake: imem_req/imem_addr are registered. Once imem_req is 1
// both hold until the cycle imem_ack=1; that cycle completes the request and
// imem_rdata is sampled. An ack seen while imem_req=0 is ignored. At most one
// request is outstanding.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         deq,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic [1:0]                   dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_req;
  logic          w_req_nxt;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;

  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc4  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   w_redir_pc;
  logic [31:0]   w_addr_p4;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_next_cnt;
  logic          w_space;

  // Word-aligned redirect target and sequential next address (32-bit wrap).
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_addr_p4  = r_addr + 32'd4;

  // Redirect beats both push and pop. A push only happens for a live
  // request in WAIT; in DRAIN the returning data is stale.
  assign w_push = (r_state == S_WAIT) && imem_ack && !redirect;
  assign w_pop  = deq && (r_count != '0) && !redirect;

  // Occupancy after this cycle's pop/push; a new request needs room for it.
  assign w_next_cnt = {1'b0, r_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
  assign w_space    = (w_next_cnt < DEPTH_C);

  // Fetch FSM: next state, next request and next fetch PC.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redir_pc;
        end else if (w_space) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redir_pc;
          if (imem_ack) begin
            // Request completed but is stale: reissue at the target now.
            w_addr_nxt = w_redir_pc;
          end else begin
            // Request still outstanding: hold it and drop its data later.
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          w_fetch_pc_nxt = w_addr_p4;
          if (w_space) begin
            w_addr_nxt = w_addr_p4;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redir_pc;
        end
        if (imem_ack) begin
          w_addr_nxt  = redirect ? w_redir_pc : r_fetch_pc;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fetch FSM state and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // FIFO storage, pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc4[i]  <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_inst[r_wr_ptr] <= imem_rdata;
        r_mem_pc4[r_wr_ptr]  <= w_addr_p4;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_next_cnt[CW-1:0];
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst       = r_mem_inst[r_rd_ptr];
  assign inst_pc4   = r_mem_pc4[r_rd_ptr];
  assign count      = r_count;
  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue (DEPTH=4, RESET_PC=0): a directed vector table
// walked cycle by cycle, then hand-written sequences for zero-wait streaming
// and asynchronous reset in the middle of a fetch.
module tb_if_prefetch_queue;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_W = 2'd1;
  localparam logic [1:0] ST_D = 2'd2;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic [2:0]  count;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .deq        (deq),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc4   (inst_pc4),
    .count      (count),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        deq;
    logic        ack;
    logic [31:0] rdata;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic [2:0]  e_cnt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic dq,
                     input logic ack, input logic [31:0] rdata,
                     input logic e_valid, input logic [31:0] e_inst,
                     input logic [31:0] e_pc4, input logic [2:0] e_cnt,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic [1:0] e_st);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.deq = dq; v.ack = ack; v.rdata = rdata;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_cnt = e_cnt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic dq,
                       input logic ack, input logic [31:0] rdata);
    redirect    = redir;
    redirect_pc = rpc;
    deq         = dq;
    imem_ack    = ack;
    imem_rdata  = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   {31'b0, imem_req},   32'd0);
    chk({tag, " addr"},  imem_addr,           32'h0);
    chk({tag, " valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, " cnt"},   {29'b0, count},      32'd0);
    chk({tag, " inst"},  inst,                32'd0);
    chk({tag, " pc4"},   inst_pc4,            32'd0);
    chk({tag, " st"},    {30'b0, dbg_state},  {30'b0, ST_I});
  endtask

  localparam logic [31:0] I0 = 32'h1000_0013, I1 = 32'h1100_0113, I2 = 32'h1200_0213;
  localparam logic [31:0] I3 = 32'h1300_0313, I4 = 32'h1400_0413, I5 = 32'h1500_0513;
  localparam logic [31:0] I6 = 32'h1600_0613, I7 = 32'h1700_0713, I8 = 32'h1800_0813;
  localparam logic [31:0] I9 = 32'h1900_0913, JUNK = 32'hDEAD_BEEF, STALE = 32'hBAD0_0001;

  initial begin
    vec_t v;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //   redir rpc           deq ack rdata  | valid inst pc4        cnt req addr          st
    add(0, 32'h0,           0, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h0,         ST_W); // 0 issue @0
    add(0, 32'h0,           1, 1, I0,      1, I0,    32'h4,       1, 1, 32'h4,         ST_W); // 1 deq empty + push
    add(0, 32'h0,           1, 1, I1,      1, I1,    32'h8,       1, 1, 32'h8,         ST_W); // 2 stream
    add(0, 32'h0,           1, 1, I2,      1, I2,    32'hC,       1, 1, 32'hC,         ST_W); // 3 stream
    add(0, 32'h0,           0, 1, I3,      1, I2,    32'hC,       2, 1, 32'h10,        ST_W); // 4 stall
    add(0, 32'h0,           0, 1, I4,      1, I2,    32'hC,       3, 1, 32'h14,        ST_W); // 5 stall
    add(0, 32'h0,           0, 1, I5,      1, I2,    32'hC,       4, 0, 32'h14,        ST_I); // 6 full, stop
    add(0, 32'h0,           0, 1, JUNK,    1, I2,    32'hC,       4, 0, 32'h14,        ST_I); // 7 ack w/o req
    add(0, 32'h0,           1, 0, 32'h0,   1, I3,    32'h10,      3, 1, 32'h18,        ST_W); // 8 pop -> reissue
    add(0, 32'h0,           0, 0, 32'h0,   1, I3,    32'h10,      3, 1, 32'h18,        ST_W); // 9 hold req
    add(0, 32'h0,           1, 1, I6,      1, I4,    32'h14,      3, 1, 32'h1C,        ST_W); // 10 push+pop wrap
    add(1, 32'h200,         1, 1, I7,      0, 32'h0, 32'h0,       0, 1, 32'h200,       ST_W); // 11 redir+ack+deq
    add(0, 32'h0,           0, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h200,       ST_W); // 12 wait
    add(1, 32'h103,         0, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h200,       ST_D); // 13 redir in WAIT
    add(0, 32'h0,           1, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h200,       ST_D); // 14 deq empty
    add(0, 32'h0,           0, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h200,       ST_D); // 15 drain
    add(0, 32'h0,           0, 1, STALE,   0, 32'h0, 32'h0,       0, 1, 32'h100,       ST_W); // 16 stale dropped
    add(0, 32'h0,           0, 1, I8,      1, I8,    32'h104,     1, 1, 32'h104,       ST_W); // 17 first @0x100
    add(0, 32'h0,           1, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h104,       ST_W); // 18 pop to empty
    add(1, 32'hFFFF_FFFF,   0, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h104,       ST_D); // 19 redir to top
    add(0, 32'h0,           0, 1, STALE,   0, 32'h0, 32'h0,       0, 1, 32'hFFFF_FFFC, ST_W); // 20 aligned target
    add(0, 32'h0,           0, 1, I9,      1, I9,    32'h0,       1, 1, 32'h0,         ST_W); // 21 addr wraps
    add(0, 32'h0,           1, 0, 32'h0,   0, 32'h0, 32'h0,       0, 1, 32'h0,         ST_W); // 22 pop

    // Reset values while held in reset
    step();
    step();
    chk_reset_outputs("rst0");
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.redir, v.rpc, v.deq, v.ack, v.rdata);
      step();
      chk($sformatf("row%0d valid", i), {31'b0, inst_valid}, {31'b0, v.e_valid});
      chk($sformatf("row%0d cnt", i),   {29'b0, count},      {29'b0, v.e_cnt});
      chk($sformatf("row%0d req", i),   {31'b0, imem_req},   {31'b0, v.e_req});
      chk($sformatf("row%0d addr", i),  imem_addr,           v.e_addr);
      chk($sformatf("row%0d st", i),    {30'b0, dbg_state},  {30'b0, v.e_st});
      if (v.e_valid) begin
        chk($sformatf("row%0d inst", i), inst,     v.e_inst);
        chk($sformatf("row%0d pc4", i),  inst_pc4, v.e_pc4);
      end
    end

    // Zero-wait streaming from reset with deq held high
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    step();
    rst = 1'b1;
    deq = 1'b1;
    step();
    chk("zw0 req",   {31'b0, imem_req},   32'd1);
    chk("zw0 addr",  imem_addr,           32'h0);
    chk("zw0 valid", {31'b0, inst_valid}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      imem_ack   = imem_req;
      imem_rdata = 32'hB000_0000 + imem_addr;
      step();
      chk($sformatf("zw%0d valid", k), {31'b0, inst_valid}, 32'd1);
      chk($sformatf("zw%0d cnt", k),   {29'b0, count},      32'd1);
      chk($sformatf("zw%0d inst", k),  inst,     32'hB000_0000 + 32'(4 * (k - 1)));
      chk($sformatf("zw%0d pc4", k),   inst_pc4, 32'(4 * k));
      chk($sformatf("zw%0d addr", k),  imem_addr, 32'(4 * k));
    end

    // Asynchronous reset between clock edges while a request is pending
    imem_ack = 1'b0;
    deq      = 1'b0;
    chk("pre-rst req", {31'b0, imem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async");
    step();
    chk_reset_outputs("async held");
    rst = 1'b1;
    step();
    chk("restart req",  {31'b0, imem_req}, 32'd1);
    chk("restart addr", imem_addr,         32'h0);
    chk("restart st",   {30'b0, dbg_state}, {30'b0, ST_W});
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    step();
    imem_ack = 1'b0;
    chk("restart inst", inst,     32'hCAFE_0001);
    chk("restart pc4",  inst_pc4, 32'h4);
    chk("restart cnt",  {29'b0, count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
